// File: rtl/bf16_log.sv
// bf16_log: pipelined bfloat16 natural logarithm.
// ln(x) = (e-127)*ln2 + ln(1.m), with ln(1.m) taken from an 8-segment
// piecewise-linear table. Three compute stages feed a registered output,
// so a token accepted at edge N is presented after edge N+3. A stall at the
// output freezes every stage.
module bf16_log (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] data_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] data_o
);

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 7;
    localparam int unsigned SEG_W    = 3;
    localparam int unsigned FINE_W   = 4;
    localparam int unsigned FRAC_W   = 16;
    localparam int unsigned SLOPE_W  = 13;
    localparam int unsigned INTERP_W = 17;
    localparam int unsigned SUM_W    = 25;
    localparam int unsigned MAG_W    = 23;
    localparam int unsigned P_W      = 5;

    localparam logic signed [SUM_W-1:0] LN2_Q16  = 25'sd45426;
    localparam logic        [EXP_W:0]   EXP_BIAS = 9'd127;
    localparam logic        [EXP_W-1:0] EXP_OFS  = 8'd111;
    localparam logic       [DATA_W-1:0] NEG_INF  = 16'hFF80;
    localparam logic       [DATA_W-1:0] POS_INF  = 16'h7F80;
    localparam logic       [DATA_W-1:0] QNAN     = 16'h7FC0;

    // ln(1 + k/8) in Q0.16 at each segment start
    function automatic logic [FRAC_W-1:0] base_of(input logic [SEG_W-1:0] k);
        case (k)
            3'd0:    return 16'd0;
            3'd1:    return 16'd7719;
            3'd2:    return 16'd14624;
            3'd3:    return 16'd20870;
            3'd4:    return 16'd26573;
            3'd5:    return 16'd31818;
            3'd6:    return 16'd36675;
            default: return 16'd41196;
        endcase
    endfunction

    // Rise of ln(1.m) across each segment (next base minus this base)
    function automatic logic [SLOPE_W-1:0] slope_of(input logic [SEG_W-1:0] k);
        case (k)
            3'd0:    return 13'd7719;
            3'd1:    return 13'd6905;
            3'd2:    return 13'd6246;
            3'd3:    return 13'd5703;
            3'd4:    return 13'd5245;
            3'd5:    return 13'd4857;
            3'd6:    return 13'd4521;
            default: return 13'd4230;
        endcase
    endfunction

    logic stall;

    // Stage 1 decode signals
    logic                     d_sign;
    logic [EXP_W-1:0]         d_exp;
    logic [MAN_W-1:0]         d_man;
    logic [INTERP_W-1:0]      interp_c;
    logic [FRAC_W-1:0]        lnm_c;
    logic signed [EXP_W:0]    e_off_c;
    logic signed [SUM_W-1:0]  e_term_c;
    logic                     spec_c;
    logic [DATA_W-1:0]        spec_val_c;

    logic                     s1_valid;
    logic [FRAC_W-1:0]        s1_lnm;
    logic signed [SUM_W-1:0]  s1_eterm;
    logic                     s1_spec;
    logic [DATA_W-1:0]        s1_spec_val;

    logic signed [SUM_W-1:0]  sum_c;
    logic                     s2_valid;
    logic signed [SUM_W-1:0]  s2_sum;
    logic                     s2_spec;
    logic [DATA_W-1:0]        s2_spec_val;

    logic [MAG_W-1:0]         mag_c;
    logic [P_W-1:0]           p_c;
    logic                     s3_valid;
    logic                     s3_neg;
    logic                     s3_zero;
    logic [MAG_W-1:0]         s3_mag;
    logic [P_W-1:0]           s3_p;
    logic                     s3_spec;
    logic [DATA_W-1:0]        s3_spec_val;

    logic [DATA_W-1:0]        pack_c;

    // Output holding a result nobody takes freezes the whole pipe
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Decode: mantissa interpolation, exponent term and special classes
    always_comb begin
        d_sign     = data_i[15];
        d_exp      = data_i[14:7];
        d_man      = data_i[6:0];
        interp_c   = INTERP_W'(slope_of(d_man[6:4])) * INTERP_W'(d_man[3:0]) + INTERP_W'(8);
        lnm_c      = base_of(d_man[6:4]) + FRAC_W'(interp_c >> FINE_W);
        e_off_c    = $signed({1'b0, d_exp}) - $signed(EXP_BIAS);
        e_term_c   = $signed({{(SUM_W-EXP_W-1){e_off_c[EXP_W]}}, e_off_c}) * LN2_Q16;
        spec_c     = 1'b0;
        spec_val_c = '0;
        if (d_exp == '0) begin
            spec_c     = 1'b1;
            spec_val_c = NEG_INF;
        end else if (d_sign || (d_exp == '1 && d_man != '0)) begin
            spec_c     = 1'b1;
            spec_val_c = QNAN;
        end else if (d_exp == '1) begin
            spec_c     = 1'b1;
            spec_val_c = POS_INF;
        end
    end

    // Stage 1 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_lnm      <= '0;
            s1_eterm    <= '0;
            s1_spec     <= 1'b0;
            s1_spec_val <= '0;
        end else if (!stall) begin
            s1_valid    <= in_valid;
            s1_lnm      <= lnm_c;
            s1_eterm    <= e_term_c;
            s1_spec     <= spec_c;
            s1_spec_val <= spec_val_c;
        end
    end

    // Combine exponent and mantissa contributions
    assign sum_c = s1_eterm + $signed(SUM_W'(s1_lnm));

    // Stage 2 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            s2_sum      <= '0;
            s2_spec     <= 1'b0;
            s2_spec_val <= '0;
        end else if (!stall) begin
            s2_valid    <= s1_valid;
            s2_sum      <= sum_c;
            s2_spec     <= s1_spec;
            s2_spec_val <= s1_spec_val;
        end
    end

    // Magnitude and leading-one position of the sum
    always_comb begin
        mag_c = MAG_W'(s2_sum[SUM_W-1] ? -s2_sum : s2_sum);
        p_c   = '0;
        for (int unsigned i = 0; i < MAG_W; i++) begin
            if (mag_c[i]) p_c = P_W'(i);
        end
    end

    // Stage 3 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid    <= 1'b0;
            s3_neg      <= 1'b0;
            s3_zero     <= 1'b0;
            s3_mag      <= '0;
            s3_p        <= '0;
            s3_spec     <= 1'b0;
            s3_spec_val <= '0;
        end else if (!stall) begin
            s3_valid    <= s2_valid;
            s3_neg      <= s2_sum[SUM_W-1];
            s3_zero     <= (s2_sum == '0);
            s3_mag      <= mag_c;
            s3_p        <= p_c;
            s3_spec     <= s2_spec;
            s3_spec_val <= s2_spec_val;
        end
    end

    // Pack into bfloat16, truncating bits below the mantissa
    always_comb begin
        pack_c = '0;
        if (s3_spec) begin
            pack_c = s3_spec_val;
        end else if (!s3_zero) begin
            pack_c = {s3_neg, EXP_W'(s3_p) + EXP_OFS,
                      MAN_W'({s3_mag, MAN_W'(0)} >> s3_p)};
        end
    end

    // Output register; data_o only changes when a new result lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_o    <= '0;
        end else if (!stall) begin
            out_valid <= s3_valid;
            if (s3_valid) data_o <= pack_c;
        end
    end

endmodule

// File: tb/tb_bf16_log.sv
// Testbench for bf16_log: directed values, backpressure, random bubbles and
// mid-flight reset, scored against a real-arithmetic reference model.
module tb_bf16_log;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [15:0] data_i    = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] data_o;

    always #5 clk = ~clk;

    bf16_log dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_i    (data_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_o    (data_o)
    );

    typedef struct {
        logic [15:0] val;
        int          acc_cyc;
        int          field;
    } exp_t;

    exp_t sb[$];
    int   base [0:8];
    int   num_checks = 0;
    int   num_errors = 0;
    int   cyc        = 0;
    int   rx_count   = 0;
    bit   check_lat  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ln(x) from the table rules in plain integer arithmetic
    function automatic logic [15:0] ref_log(input logic [15:0] x);
        int e, m, seg, frac, lnm, sum, mag, p, mant;
        e = int'(x[14:7]);
        m = int'(x[6:0]);
        if (e == 0) return 16'hFF80;
        if (e == 255 && m != 0) return 16'h7FC0;
        if (x[15]) return 16'h7FC0;
        if (e == 255) return 16'h7F80;
        seg  = m / 16;
        frac = m % 16;
        lnm  = base[seg] + ((base[seg+1] - base[seg]) * frac + 8) / 16;
        sum  = (e - 127) * base[8] + lnm;
        if (sum == 0) return 16'h0000;
        mag = (sum < 0) ? -sum : sum;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        mant = (p >= 7) ? (mag >> (p - 7)) % 128 : (mag << (7 - p)) % 128;
        return {sum < 0, 8'(p + 111), 7'(mant)};
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Drive one cycle's inputs, then score whatever transfers on the next edge
    task automatic apply(input bit iv, input logic [15:0] d, input bit ordy,
                         input logic [15:0] ev, input int field, output bit acc);
        exp_t e;
        exp_t o;
        in_valid  = iv;
        data_i    = d;
        out_ready = ordy;
        #1;
        acc = iv && in_ready;
        if (out_valid && out_ready) begin
            rx_count++;
            check_eq("sb_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                o = sb.pop_front();
                check_eq("data_o", 32'(data_o), 32'(o.val));
                if (o.field >= 0) check_eq("ext_sign_exp", 32'(data_o[15:7]), 32'(o.field));
                if (check_lat) check_eq("latency", 32'(cyc - o.acc_cyc), 32'd4);
            end
        end
        if (acc) begin
            e.val     = ev;
            e.acc_cyc = cyc;
            e.field   = field;
            sb.push_back(e);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", num_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] dir_op  [0:10];
        logic [15:0] dir_exp [0:10];
        int          dir_fld [0:10];
        logic [15:0] bp_op   [0:5];
        logic [15:0] d;
        logic [15:0] held;
        bit          acc;
        bit          iv;
        int          sent;
        int          stall_left;
        bit          first_seen;
        int          rx_before;

        for (int k = 0; k <= 8; k++)
            base[k] = $rtoi($ln(1.0 + real'(k) / 8.0) * 65536.0 + 0.5);

        dir_op  = '{16'h3F80, 16'h4000, 16'h3F00, 16'h3FC0, 16'h0000, 16'h8000,
                    16'hBF80, 16'h7FC1, 16'h7F80, 16'h7F7F, 16'h0080};
        dir_exp = '{16'h0000, 16'h3F31, 16'hBF31, 16'h3ECF, 16'hFF80, 16'hFF80,
                    16'h7FC0, 16'h7FC0, 16'h7F80, ref_log(16'h7F7F), ref_log(16'h0080)};
        dir_fld = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, 133, 256 + 133};

        // Reset state
        repeat (3) tick();
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data_o", 32'(data_o), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        apply(1'b0, 16'h0, 1'b1, 16'h0, -1, acc);
        check_eq("post_rst_valid", 32'(out_valid), 32'd0);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed stream with exact latency
        check_lat = 1'b1;
        rx_count  = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            apply(1'b1, dir_op[i], 1'b1, dir_exp[i], dir_fld[i], acc);
            check_eq("dir_accept", 32'(acc), 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            apply(1'b0, 16'h0, 1'b1, 16'h0, -1, acc);
        end
        check_eq("dir_rx_count", 32'(rx_count), 32'd11);
        check_eq("dir_drained", 32'(sb.size()), 32'd0);
        check_lat = 1'b0;

        // Backpressure: 6 inputs, 5-cycle stall from the first out_valid
        for (int i = 0; i < 6; i++) bp_op[i] = 16'($urandom_range(16'h0080, 16'h7F7F));
        rx_count   = 0;
        sent       = 0;
        stall_left = 5;
        first_seen = 1'b0;
        held       = '0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (out_valid && !first_seen) begin
                first_seen = 1'b1;
                held       = data_o;
            end
            d = bp_op[(sent < 6) ? sent : 5];
            apply(sent < 6, d, !(first_seen && stall_left > 0), ref_log(d), -1, acc);
            if (acc) sent++;
            if (first_seen && stall_left > 0) begin
                check_eq("bp_in_ready", 32'(in_ready), 32'd0);
                check_eq("bp_out_valid", 32'(out_valid), 32'd1);
                check_eq("bp_data_hold", 32'(data_o), 32'(held));
                stall_left--;
            end
        end
        check_eq("bp_first_seen", 32'(first_seen), 32'd1);
        check_eq("bp_sent", 32'(sent), 32'd6);
        check_eq("bp_rx_count", 32'(rx_count), 32'd6);
        check_eq("bp_drained", 32'(sb.size()), 32'd0);

        // Random operands with random bubbles and backpressure
        sent = 0;
        for (int c = 0; c < 60000 && (sent < 10000 || sb.size() != 0); c++) begin
            tick();
            iv = (sent < 10000) && ($urandom_range(0, 3) != 0);
            d  = 16'($urandom);
            apply(iv, d, $urandom_range(0, 3) != 0, ref_log(d), -1, acc);
            if (acc) sent++;
        end
        check_eq("rand_sent", 32'(sent), 32'd10000);
        check_eq("rand_drained", 32'(sb.size()), 32'd0);

        // Reset with three tokens in flight
        for (int i = 0; i < 3; i++) begin
            tick();
            d = 16'($urandom);
            apply(1'b1, d, 1'b1, ref_log(d), -1, acc);
        end
        tick();
        apply(1'b0, 16'h0, 1'b1, 16'h0, -1, acc);
        tick();
        apply(1'b0, 16'h0, 1'b0, 16'h0, -1, acc);
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_data", 32'(data_o), 32'd0);
        sb.delete();
        tick();
        tick();
        rst_n     = 1'b1;
        rx_before = rx_count;
        for (int i = 0; i < 10; i++) begin
            tick();
            apply(1'b0, 16'h0, 1'b1, 16'h0, -1, acc);
            check_eq("no_stale_valid", 32'(out_valid), 32'd0);
        end
        check_eq("no_stale_rx", 32'(rx_count), 32'(rx_before));

        // Recovery after reset
        check_lat = 1'b1;
        tick();
        apply(1'b1, 16'h4000, 1'b1, 16'h3F31, -1, acc);
        for (int i = 0; i < 6; i++) begin
            tick();
            apply(1'b0, 16'h0, 1'b1, 16'h0, -1, acc);
        end
        check_eq("recover_rx", 32'(rx_count - rx_before), 32'd1);
        check_eq("recover_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
